sound_i2s_tx: RTL and testbench
===============================

# sound_i2s_tx

Serial audio transmitter that consumes the mixer's limited output and drives an external I2S DAC. Once per frame it latches one signed mono sample from a sound interface and serialises it MSB-first into both the left and right slots. It generates the bit clock, word-select and data lines from the system clock. It also produces a per-frame strobe so upstream stages can pace sample production.

## Interface
- BCLK_DIV, 4: CLK cycles per BCLK half-period; must be ≥1.
- SLOT_WIDTH, 16: bits per channel slot; must be ≥2.
- BIT_WIDTH: not a parameter; taken from `$bits(IN.Signal)` (mixer default 10).

- CLK  in  1  system clock; all logic on rising edge.
- RESET_n  in  1  reset, asynchronous assert, active-low.
- IN  SOUND_IF.IN  BIT_WIDTH  signed two's-complement mono sample.
- MUTE  in  1  when 1 at latch time, transmit zero.
- STROBE  out  1  one-CLK pulse when a sample is latched.
- BCLK  out  1  I2S bit clock.
- LRCLK  out  1  word select; 0 = left, 1 = right.
- SDATA  out  1  serial data.

## Operation
- **Divider.** `div_cnt` counts 0..BCLK_DIV-1. On a CLK edge with `div_cnt == BCLK_DIV-1`, `div_cnt` returns to 0 and BCLK toggles. That 1→0 toggle is a falling event.
- **Bit position.** `p` counts 0..2·SLOT_WIDTH-1 and wraps to 0. It advances only on falling events.
- **Output update.** On the same CLK edge that advances `p`, LRCLK and SDATA are updated from the new `p`:
  - LRCLK = 0 for p in 0..SLOT_WIDTH-1, and 1 otherwise.
  - SDATA at p≥1 = bit (2·SLOT_WIDTH − p) of the 2·SLOT_WIDTH-bit word {L_slot, R_slot}. This gives the standard I2S one-BCLK delay after each LRCLK change.
  - SDATA at p=0 = bit 0 of the previous frame's word.
- **Latch at p=0.** On the falling event that enters p=0:
  - Capture IN and MUTE.
  - Build slot S, then set word = {S, S}.
  - Assert STROBE for exactly that one CLK cycle.
- **Slot formatting** (arithmetic is on the captured value only):
  - If BIT_WIDTH ≤ SLOT_WIDTH: S = IN << (SLOT_WIDTH − BIT_WIDTH), zero-filled in the LSBs.
  - Otherwise: S = IN[BIT_WIDTH-1 : BIT_WIDTH-SLOT_WIDTH]. Excess LSBs are truncated, not rounded.
  - If MUTE = 1: S = 0.
- **Input stability.** Changes to IN or MUTE between latches have no effect on the bits already being transmitted.
- **Reset values.** On RESET_n=0, immediately:
  - Outputs: BCLK=0, LRCLK=0, SDATA=0, STROBE=0.
  - Internal: `div_cnt`=0, `p`=2·SLOT_WIDTH−1, word=0.
  - A reset asserted mid-frame abandons that frame. There is no partial-frame completion.
- **No handshake.** STROBE is informational only. Upstream must hold IN valid at least on the cycle STROBE rises; the sample is sampled on that same edge.

## Timing
- Edges are numbered from the first rising CLK edge after RESET_n deasserts, which is edge 1.
- BCLK rises at edge BCLK_DIV and falls at edge 2·BCLK_DIV.
- The first falling event enters p=0: STROBE=1 and LRCLK=0 after edge 2·BCLK_DIV, and SDATA = 0 (bit 0 of the reset word).
- Later falling events occur every 2·BCLK_DIV edges.
- Frame period is 4·SLOT_WIDTH·BCLK_DIV CLK cycles; with the defaults this is 256.
- Latency from IN capture to SDATA carrying S's MSB is 2·BCLK_DIV CLK cycles (p=1).
- The last bit of a word (R LSB) appears at p=0 of the next frame.
- SDATA and LRCLK change only on falling events, so they are stable across each BCLK rising edge (the DAC sample point).
- STROBE is high for exactly 1 cycle per frame and never on consecutive cycles. This holds even with BCLK_DIV=1.
- All outputs are registered; there is no combinational path from IN or MUTE to any output.

## Test plan
1. **Reset.** Hold RESET_n=0 with random IN → BCLK, LRCLK, SDATA and STROBE all 0. Release → first STROBE exactly at edge 8 (defaults).
2. **Positive sample.** BIT_WIDTH=10, defaults, IN=0x155 → at p=1..16 SDATA reads 0x5540 MSB-first. At p=17..32 (wrapping to p=0 of the next frame) it reads 0x5540 again. LRCLK is 0 for p=0..15 and 1 for p=16..31.
3. **Negative sample and mid-frame change.** IN=0x3FF (−1) latched, then IN changes to 0x000 at p=5 → both slots still read 0xFFC0. The next frame reads 0x0000.
4. **Mute.** MUTE=1 at a latch with IN=0x1FF → both slots 0x0000. MUTE=0 at the next latch → 0x7FC0.
5. **Truncation and divider extremes.** BIT_WIDTH=20, SLOT_WIDTH=16, BCLK_DIV=1, IN=0xABCDE → slots 0xABCD. Frame period 64 cycles; STROBE period 64 cycles.
6. **Reset mid-frame.** Assert RESET_n=0 at p=20 → outputs 0 within the same cycle. After release, timing restarts as in test 1, and the first frame's p=0 SDATA is 0.

Source files
------------

// File: rtl/sound_i2s_tx_if.sv
// SOUND_IF: carries one signed mono audio sample between sound-pipeline stages.
//   Signal  BIT_WIDTH  signed two's-complement sample
// Modports: master/OUT drive the sample, slave/IN consume it.
interface SOUND_IF #(
    parameter int BIT_WIDTH = 10
);
    logic signed [BIT_WIDTH-1:0] Signal;

    modport master (output Signal);
    modport slave  (input  Signal);
    modport OUT    (output Signal);
    modport IN     (input  Signal);
endinterface

// File: rtl/sound_i2s_tx.sv
// sound_i2s_tx: I2S transmitter for a mono sample duplicated into both slots.
// Ports:
//   CLK      in   system clock, rising edge
//   RESET_n  in   asynchronous active-low reset
//   IN       in   SOUND_IF.IN, signed sample, width taken from IN.Signal
//   MUTE     in   transmit silence for the frame being latched
//   STROBE   out  one-CLK pulse on the cycle a sample is latched
//   BCLK     out  bit clock (CLK / (2*BCLK_DIV))
//   LRCLK    out  word select, 0 = left slot, 1 = right slot
//   SDATA    out  serial data, MSB first, one BCLK behind LRCLK
module sound_i2s_tx #(
    parameter int BCLK_DIV   = 4,
    parameter int SLOT_WIDTH = 16
) (
    input  logic CLK,
    input  logic RESET_n,
    SOUND_IF.IN  IN,
    input  logic MUTE,
    output logic STROBE,
    output logic BCLK,
    output logic LRCLK,
    output logic SDATA
);
    localparam int BIT_WIDTH = $bits(IN.Signal);
    localparam int WORD_W    = 2 * SLOT_WIDTH;
    localparam int DIV_W     = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int P_W       = $clog2(WORD_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [P_W-1:0]   P_LAST   = P_W'(WORD_W - 1);

    logic [DIV_W-1:0]      div_cnt;
    logic [P_W-1:0]        p;
    logic [P_W-1:0]        p_next;
    logic [P_W-1:0]        bit_idx;
    logic [WORD_W-1:0]     word;
    logic [SLOT_WIDTH-1:0] slot;
    logic                  div_end;
    logic                  fall_evt;
    logic                  sdata_next;

    assign div_end  = (div_cnt == DIV_LAST);
    // BCLK is about to toggle while high: this edge is a falling event.
    assign fall_evt = div_end & BCLK;
    assign p_next   = (p == P_LAST) ? '0 : p + 1'b1;
    // WORD_W - p_next; always fits in P_W bits for p_next >= 1.
    assign bit_idx  = P_LAST - p_next + P_W'(1);

    // Align the sample to the slot MSB: pad LSBs with zeros or drop excess LSBs.
    generate
        if (BIT_WIDTH <= SLOT_WIDTH) begin : g_pad
            always_comb slot = SLOT_WIDTH'(IN.Signal) << (SLOT_WIDTH - BIT_WIDTH);
        end else begin : g_trunc
            always_comb slot = IN.Signal[BIT_WIDTH-1 -: SLOT_WIDTH];
        end
    endgenerate

    // At p=0 the outgoing bit is the old word's LSB (R slot LSB of the
    // previous frame), which gives the one-BCLK I2S delay.
    always_comb begin
        sdata_next = word[0];
        if (p_next != '0) sdata_next = word[bit_idx];
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            div_cnt <= '0;
            BCLK    <= 1'b0;
            p       <= P_LAST;
            word    <= '0;
            LRCLK   <= 1'b0;
            SDATA   <= 1'b0;
            STROBE  <= 1'b0;
        end else begin
            STROBE <= 1'b0;
            if (div_end) begin
                div_cnt <= '0;
                BCLK    <= ~BCLK;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fall_evt) begin
                p     <= p_next;
                LRCLK <= (p_next >= P_W'(SLOT_WIDTH));
                SDATA <= sdata_next;
                if (p_next == '0) begin
                    word   <= MUTE ? '0 : {slot, slot};
                    STROBE <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sound_i2s_tx.sv
module tb_sound_i2s_tx;
    localparam int D_A = 4;
    localparam int D_B = 1;
    localparam int SW  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic mute_a = 1'b0, mute_b = 1'b0;
    logic strobe_a, bclk_a, lrclk_a, sdata_a;
    logic strobe_b, bclk_b, lrclk_b, sdata_b;

    SOUND_IF #(.BIT_WIDTH(10)) sif_a();
    SOUND_IF #(.BIT_WIDTH(20)) sif_b();

    sound_i2s_tx #(.BCLK_DIV(D_A), .SLOT_WIDTH(SW)) dut_a (
        .CLK(clk), .RESET_n(rst_n), .IN(sif_a), .MUTE(mute_a),
        .STROBE(strobe_a), .BCLK(bclk_a), .LRCLK(lrclk_a), .SDATA(sdata_a));

    sound_i2s_tx #(.BCLK_DIV(D_B), .SLOT_WIDTH(SW)) dut_b (
        .CLK(clk), .RESET_n(rst_n), .IN(sif_b), .MUTE(mute_b),
        .STROBE(strobe_b), .BCLK(bclk_b), .LRCLK(lrclk_b), .SDATA(sdata_b));

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // n = rising edges since reset release; frame words are remembered per latch.
    int          n_a, n_b;
    logic [31:0] wc_a, wp_a, wc_b, wp_b;

    function automatic logic [31:0] fmt(logic [31:0] v, int bw, logic m);
        logic [15:0] s;
        if (m)            s = '0;
        else if (bw <= 16) s = 16'(v << (16 - bw));
        else               s = 16'(v >> (bw - 16));
        return {s, s};
    endfunction

    function automatic logic is_latch(int n, int d);
        return (n >= 2 * d) && ((n - 2 * d) % (4 * SW * d) == 0);
    endfunction

    // Returns {BCLK, LRCLK, SDATA, STROBE} expected after edge n.
    function automatic logic [3:0] exp_out(int n, int d, logic [31:0] wc, logic [31:0] wp);
        logic b, lr, sd, st;
        int k, p;
        b = 0; lr = 0; sd = 0; st = 0;
        if (n > 0) begin
            b = ((n / d) % 2) == 1;
            k = n / (2 * d);
            if (k > 0) begin
                p  = (k - 1) % (2 * SW);
                lr = (p >= SW);
                sd = (p == 0) ? wp[0] : wc[2 * SW - p];
                st = (n % (2 * d) == 0) && (p == 0);
            end
        end
        return {b, lr, sd, st};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_a <= 0; wc_a <= '0; wp_a <= '0;
            n_b <= 0; wc_b <= '0; wp_b <= '0;
        end else begin
            n_a <= n_a + 1;
            n_b <= n_b + 1;
            if (is_latch(n_a + 1, D_A)) begin
                wp_a <= wc_a;
                wc_a <= fmt(32'(sif_a.Signal), 10, mute_a);
            end
            if (is_latch(n_b + 1, D_B)) begin
                wp_b <= wc_b;
                wc_b <= fmt(32'(sif_b.Signal), 20, mute_b);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Waits for a fresh STROBE, then records SDATA/LRCLK at the next 2*SW
    // falling BCLK events (p=1..2*SW, the last being p=0 of the next frame).
    // Optionally drives new IN/MUTE right after the bit at position chg_p.
    task automatic collect(input int sel, input int chg_p, input logic [19:0] chg_val,
                           input logic chg_mute, output logic [31:0] sd,
                           output logic [31:0] lr, output bit ok);
        int d, w;
        logic pb, cur, fell, st;
        d = (sel == 0) ? D_A : D_B;
        ok = 1; sd = '0; lr = '0; w = 0;
        do begin
            @(negedge clk);
            w++;
            st = (sel == 0) ? strobe_a : strobe_b;
        end while (!st && w < 4 * SW * d + 4);
        if (!st) begin ok = 0; return; end
        pb = 1'b0;
        for (int p = 1; p <= 2 * SW; p++) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
                cur  = (sel == 0) ? bclk_a : bclk_b;
                fell = pb && !cur;
                pb   = cur;
            end while (!fell && w <= 2 * d + 1);
            if (!fell) begin ok = 0; return; end
            sd = {sd[30:0], (sel == 0) ? sdata_a : sdata_b};
            lr = {lr[30:0], (sel == 0) ? lrclk_a : lrclk_b};
            if (p == chg_p) begin
                if (sel == 0) begin sif_a.Signal = chg_val[9:0]; mute_a = chg_mute; end
                else          begin sif_b.Signal = chg_val;      mute_b = chg_mute; end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int first, rise;
        logic sd_first;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sif_a.Signal = 10'($urandom);
            sif_b.Signal = 20'($urandom);
            @(negedge clk);
            n_cmp++;
            if ({bclk_a, lrclk_a, sdata_a, strobe_a} !== 4'b0 ||
                {bclk_b, lrclk_b, sdata_b, strobe_b} !== 4'b0) begin
                n_err++;
                $display("FAIL reset_outputs: got a=%b b=%b want 0000",
                         {bclk_a, lrclk_a, sdata_a, strobe_a}, {bclk_b, lrclk_b, sdata_b, strobe_b});
            end
        end
        rst_n = 1'b1;
        first = -1; rise = -1; sd_first = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bclk_a && rise < 0) rise = i;
            if (strobe_a && first < 0) begin first = i; sd_first = sdata_a; end
        end
        n_cmp++;
        if (first !== 8) begin n_err++; $display("FAIL first_strobe_edge: got %0d want 8", first); end
        n_cmp++;
        if (rise !== 4) begin n_err++; $display("FAIL first_bclk_rise_edge: got %0d want 4", rise); end
        n_cmp++;
        if (sd_first !== 1'b0) begin n_err++; $display("FAIL first_p0_sdata: got %b want 0", sd_first); end
    endtask

    task automatic test_positive();
        logic [31:0] sd, lr;
        bit ok;
        sif_a.Signal = 10'h155; mute_a = 1'b0;
        collect(0, -1, 20'h0, 1'b0, sd, lr, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL pos_timeout: no frame seen"); end
        n_cmp++;
        if (sd !== 32'h5540_5540) begin n_err++; $display("FAIL pos_sdata: got %h want 55405540", sd); end
        n_cmp++;
        if (lr !== 32'h0001_FFFE) begin n_err++; $display("FAIL pos_lrclk: got %h want 0001fffe", lr); end
    endtask

    task automatic test_negative_midchange();
        logic [31:0] sd, lr;
        bit ok;
        sif_a.Signal = 10'h3FF; mute_a = 1'b0;
        collect(0, 5, 20'h0, 1'b0, sd, lr, ok);
        n_cmp++;
        if (!ok || sd !== 32'hFFC0_FFC0) begin
            n_err++; $display("FAIL neg_sdata: got %h ok=%0d want ffc0ffc0", sd, ok);
        end
        collect(0, -1, 20'h0, 1'b0, sd, lr, ok);
        n_cmp++;
        if (!ok || sd !== 32'h0) begin
            n_err++; $display("FAIL neg_next_frame: got %h ok=%0d want 00000000", sd, ok);
        end
    endtask

    task automatic test_mute();
        logic [31:0] sd, lr;
        bit ok;
        sif_a.Signal = 10'h1FF; mute_a = 1'b1;
        collect(0, 5, 20'h1FF, 1'b0, sd, lr, ok);
        n_cmp++;
        if (!ok || sd !== 32'h0) begin
            n_err++; $display("FAIL mute_on: got %h ok=%0d want 00000000", sd, ok);
        end
        collect(0, -1, 20'h0, 1'b0, sd, lr, ok);
        n_cmp++;
        if (!ok || sd !== 32'h7FC0_7FC0) begin
            n_err++; $display("FAIL mute_off: got %h ok=%0d want 7fc07fc0", sd, ok);
        end
    endtask

    task automatic test_truncation();
        logic [31:0] sd, lr;
        bit ok;
        int c;
        sif_b.Signal = 20'hABCDE; mute_b = 1'b0;
        collect(1, -1, 20'h0, 1'b0, sd, lr, ok);
        n_cmp++;
        if (!ok || sd !== 32'hABCD_ABCD) begin
            n_err++; $display("FAIL trunc_sdata: got %h ok=%0d want abcdabcd", sd, ok);
        end
        n_cmp++;
        if (lr !== 32'h0001_FFFE) begin n_err++; $display("FAIL trunc_lrclk: got %h want 0001fffe", lr); end
        c = 0;
        do begin @(negedge clk); c++; end while (!strobe_b && c < 200);
        n_cmp++;
        if (c !== 64) begin n_err++; $display("FAIL trunc_strobe_period: got %0d want 64", c); end
    endtask

    task automatic test_random_stream();
        logic [3:0] ga, gb, ea, eb;
        for (int i = 0; i < 3 * 4 * SW * D_A; i++) begin
            @(negedge clk);
            ga = {bclk_a, lrclk_a, sdata_a, strobe_a};
            gb = {bclk_b, lrclk_b, sdata_b, strobe_b};
            ea = exp_out(n_a, D_A, wc_a, wp_a);
            eb = exp_out(n_b, D_B, wc_b, wp_b);
            n_cmp++;
            if (ga !== ea) begin n_err++; $display("FAIL rand_a n=%0d: got %b want %b", n_a, ga, ea); end
            n_cmp++;
            if (gb !== eb) begin n_err++; $display("FAIL rand_b n=%0d: got %b want %b", n_b, gb, eb); end
            if ($urandom_range(0, 15) == 0) sif_a.Signal = 10'($urandom);
            if ($urandom_range(0, 7) == 0)  sif_b.Signal = 20'($urandom);
            if ($urandom_range(0, 63) == 0) mute_a = ~mute_a;
            if ($urandom_range(0, 31) == 0) mute_b = ~mute_b;
        end
    endtask

    task automatic test_reset_midframe();
        int w, first;
        logic [3:0] ga, ea;
        sif_a.Signal = 10'h2AB; mute_a = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!strobe_a && w < 300);
        // Advance to p=20 with BCLK high so every output has something to clear.
        repeat (20 * 2 * D_A + D_A) @(negedge clk);
        n_cmp++;
        if ({bclk_a, lrclk_a} !== 2'b11) begin
            n_err++; $display("FAIL mid_precondition: got bclk,lrclk=%b want 11", {bclk_a, lrclk_a});
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bclk_a, lrclk_a, sdata_a, strobe_a} !== 4'b0) begin
            n_err++; $display("FAIL mid_reset_outputs: got %b want 0000", {bclk_a, lrclk_a, sdata_a, strobe_a});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        first = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (strobe_a && first < 0) first = i;
            ga = {bclk_a, lrclk_a, sdata_a, strobe_a};
            ea = exp_out(n_a, D_A, wc_a, wp_a);
            n_cmp++;
            if (ga !== ea) begin n_err++; $display("FAIL mid_restart n=%0d: got %b want %b", n_a, ga, ea); end
        end
        n_cmp++;
        if (first !== 8) begin n_err++; $display("FAIL mid_first_strobe: got %0d want 8", first); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_positive();
        test_negative_midchange();
        test_mute();
        test_truncation();
        test_random_stream();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
